counter_event_logger: RTL
=========================

COUNTER_EVENT_LOGGER -- requirements
Module: counter_event_logger

Interface
- REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; legal values are powers of two from 4 to 256.
- REQ-002 SHALL have port clk1, input, 1 bit: sole clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset1_n, input, 1 bit: reset, asynchronous assert, active-low.
- REQ-004 SHALL have port count, input, 8 bits: counter value sampled when logging an event.
- REQ-005 SHALL have port evt_eq00, input, 1 bit: level, high while the counter equals 0x00.
- REQ-006 SHALL have port evt_eq80, input, 1 bit: level, high while the counter equals 0x80.
- REQ-007 SHALL have port log_en, input, 1 bit: high enables capture of new events.
- REQ-008 SHALL have port clr, input, 1 bit: one-cycle synchronous clear pulse.
- REQ-009 SHALL have port rd_en, input, 1 bit: one-cycle pop request.
- REQ-010 SHALL have port dout, output, 32 bits: oldest entry, laid out as {timestamp[15:0], code[1:0], 6'b0, count[7:0]}.
- REQ-011 SHALL have port empty, output, 1 bit: FIFO holds no entries.
- REQ-012 SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
- REQ-013 SHALL have port level, output, 9 bits: current entry count, 0 to DEPTH.
- REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
- REQ-015 SHALL have port drop_count, output, 8 bits: count of dropped events, saturating at 0xFF.
- REQ-016 SHALL have port evt_pulse, output, 1 bit: one-cycle pulse for every detected event, whether stored or dropped.

Function
- REQ-017 SHALL keep a free-running 16-bit timestamp that increments every cycle and wraps 0xFFFF->0x0000.
- REQ-018 SHALL register evt_eq00 and evt_eq80 each cycle; an event is the input being 1 in cycle N and 0 in cycle N-1.
- REQ-019 SHALL encode code as 2'b01 for an eq00 event, 2'b10 for an eq80 event, and 2'b11 for both in the same cycle; both together produce one entry.
- REQ-020 SHALL write an event detected in cycle N with log_en=1 at the end of cycle N, storing the timestamp and count values of cycle N; empty falls and level rises in cycle N+1.
- REQ-021 SHALL ignore events while log_en=0 (no write, no drop); edge history still updates.
- REQ-022 SHALL present dout first-word-fall-through: the oldest entry whenever empty=0, and 32'h0 when empty=1.
- REQ-023 SHALL pop on rd_en=1 with empty=0, so the next entry appears on dout in the following cycle.
- REQ-024 SHALL ignore rd_en when empty=1, leaving level unchanged with no side effects.
- REQ-025 SHALL, on write and pop in the same cycle with a non-empty FIFO, perform both with level unchanged; this includes the full case, where the write succeeds.
- REQ-026 SHALL, on a write while full with no pop, drop the entry, set overflow, and increment drop_count, saturating at 0xFF.
- REQ-027 SHALL, on write and rd_en in the same cycle while empty, store the entry and ignore the read.
- REQ-028 SHALL let clr take priority over a same-cycle write or read: empty the FIFO, clear overflow and drop_count, and load timestamp 0x0000; edge history is unaffected.
- REQ-029 SHALL drive evt_pulse high in cycle N+1 for an event detected in cycle N.
- REQ-030 SHALL assert full exactly when level == DEPTH and empty exactly when level == 0, with both registered.
- REQ-031 SHALL wrap read and write pointers modulo DEPTH.

Reset
- REQ-032 SHALL, with reset1_n=0, asynchronously clear: timestamp=0, pointers=0, level=0, empty=1, full=0, overflow=0, drop_count=0, evt_pulse=0, edge history=0.
- REQ-033 SHALL hold dout at 32'h0 during reset.
- REQ-034 SHALL, because edge history resets to 0, log any input already high in the first cycle after reset release.
- REQ-035 SHALL let an asserted reset1_n mid-operation discard all entries immediately.

Verification
- REQ-036 SHALL cover: reset release with evt_eq00=1, log_en=1 -> one entry with code=01, count=0x00, timestamp=0x0000; empty=0 one cycle later.
- REQ-037 SHALL cover: evt_eq80 rises at timestamp 0x1234 with count=0x80 -> dout=32'h1234_8080; rd_en -> empty=1, dout=0.
- REQ-038 SHALL cover: DEPTH+3 events, no reads -> full=1, level=DEPTH, overflow=1, drop_count=3; draining returns the first DEPTH entries in order.
- REQ-039 SHALL cover: full FIFO with simultaneous event and rd_en -> level stays DEPTH, no drop, newest entry last.
- REQ-040 SHALL cover: timestamp crossing 0xFFFF, then clr in the same cycle as an event and rd_en -> FIFO empty, overflow=0, timestamp=0x0000 next cycle, event not stored.
- REQ-041 SHALL cover: log_en=0 during 5 edges -> level stays 0, evt_pulse stays low; reset1_n low mid-fill -> all outputs at reset values immediately.

Source files
------------

// File: rtl/counter_event_logger.sv
// Event logger: detects rising edges on the counter-equals-0x00/0x80 flags and
// queues {timestamp, code, count} records in a first-word-fall-through FIFO.
module counter_event_logger #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk1,
  input  logic        reset1_n,
  input  logic [7:0]  count,
  input  logic        evt_eq00,
  input  logic        evt_eq80,
  input  logic        log_en,
  input  logic        clr,
  input  logic        rd_en,
  output logic [31:0] dout,
  output logic        empty,
  output logic        full,
  output logic [8:0]  level,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        evt_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = 9;

  logic          r_eq00_d;
  logic          r_eq80_d;
  logic [15:0]   r_ts;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic [7:0]    r_drop_count;
  logic          r_evt_pulse;
  logic [31:0]   r_dout;
  logic [31:0]   r_mem [DEPTH];

  logic          w_ev00;
  logic          w_ev80;
  logic [1:0]    w_code;
  logic          w_log;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_entry;
  logic [LW-1:0] w_level_nxt;
  logic [31:0]   w_head_nxt;

  assign w_ev00  = evt_eq00 & ~r_eq00_d;
  assign w_ev80  = evt_eq80 & ~r_eq80_d;
  assign w_code  = {w_ev80, w_ev00};
  assign w_log   = (|w_code) & log_en;
  assign w_pop   = rd_en & ~r_empty & ~clr;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign w_push  = w_log & ~clr & (~r_full | w_pop);
  assign w_drop  = w_log & ~clr & r_full & ~w_pop;
  assign w_entry = {r_ts, w_code, 6'b0, count};

  // Next occupancy and next head-of-queue word, so dout can be held in a register.
  always_comb begin
    w_level_nxt = r_level;
    w_head_nxt  = r_dout;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (w_pop && !w_push) w_level_nxt = r_level - LW'(1);
    if (w_level_nxt == '0)     w_head_nxt = '0;
    else if (r_empty)          w_head_nxt = w_entry;
    else if (w_pop)            w_head_nxt = (r_level == LW'(1)) ? w_entry
                                                                : r_mem[r_rd_ptr + AW'(1)];
  end

  always_ff @(posedge clk1 or negedge reset1_n) begin
    if (!reset1_n) begin
      r_eq00_d     <= 1'b0;
      r_eq80_d     <= 1'b0;
      r_ts         <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_evt_pulse  <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_eq00_d    <= evt_eq00;
      r_eq80_d    <= evt_eq80;
      r_evt_pulse <= w_log;
      if (clr) begin
        r_ts         <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_level      <= '0;
        r_empty      <= 1'b1;
        r_full       <= 1'b0;
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
        r_dout       <= '0;
      end else begin
        r_ts    <= r_ts + 16'(1);
        r_level <= w_level_nxt;
        r_empty <= (w_level_nxt == '0);
        r_full  <= (w_level_nxt == LW'(DEPTH));
        r_dout  <= w_head_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'(1);
        end
      end
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk1) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign dout       = r_dout;
  assign empty      = r_empty;
  assign full       = r_full;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign evt_pulse  = r_evt_pulse;

endmodule
